// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
//
// Turns the raw scan-code byte stream from a PS/2 receiver into key events.
// The E0 (extended) and F0 (break) prefixes are folded into flags on the
// event, and the keyboard error codes 0x00/0xFF are discarded. Decoded
// events are queued in a small FIFO for the consumer.
//
// Build option: define PS2_EXTENDED_EN to decode E0-prefixed keys. Without
// it, 0xE0 is ignored in every state and ev_ext is tied to 0.
//
// Parameters
//   FIFO_DEPTH      event FIFO entries (power of two, 2..16)
//   TIMEOUT_CYCLES  clk cycles a pending prefix may wait for its next byte
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   byte_in      scan-code byte from the PS/2 receiver
//   byte_valid   one-cycle strobe qualifying byte_in
//   ev_ready     consumer accepts the head event
//   ev_valid     FIFO not empty, head event presented
//   ev_code      head event key code (prefixes stripped)
//   ev_break     head event is a release
//   ev_ext       head event carried the E0 prefix
//   ovf          sticky: an event was dropped on a full FIFO
//   fifo_count   number of occupied FIFO entries
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    input  logic                          ev_ready,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_break,
    output logic                          ev_ext,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_EXTENDED_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_F0   = 2'd1,
        GOT_E0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;
`else
    typedef enum logic {
        IDLE   = 1'b0,
        GOT_F0 = 1'b1
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            is_e0, is_f0, is_err;
    logic            timeout_hit;
    logic            emit;
    logic            emit_brk;
`ifdef PS2_EXTENDED_EN
    logic            emit_ext;
`endif

    assign is_e0  = (byte_in == 8'hE0);
    assign is_f0  = (byte_in == 8'hF0);
    assign is_err = (byte_in == 8'h00) || (byte_in == 8'hFF);

    // A prefix that never gets its follow-up byte is abandoned silently.
    assign timeout_hit = (state_q != IDLE) && (tmo_q == TO_LAST);

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_brk = 1'b0;
`ifdef PS2_EXTENDED_EN
        emit_ext = 1'b0;
`endif
        if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_f0) begin
                        state_d = GOT_F0;
`ifdef PS2_EXTENDED_EN
                    end else if (is_e0) begin
                        state_d = GOT_E0;
`else
                    end else if (is_e0) begin
                        state_d = IDLE;
`endif
                    end else if (!is_err) begin
                        emit = 1'b1;
                    end
                end
                GOT_F0: begin
                    if (is_f0) begin
                        state_d = GOT_F0;
`ifdef PS2_EXTENDED_EN
                    // E0 after F0 restarts an extended make sequence.
                    end else if (is_e0) begin
                        state_d = GOT_E0;
`else
                    end else if (is_e0) begin
                        state_d = GOT_F0;
`endif
                    end else if (is_err) begin
                        state_d = IDLE;
                    end else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = IDLE;
                    end
                end
`ifdef PS2_EXTENDED_EN
                GOT_E0: begin
                    if (is_f0) begin
                        state_d = GOT_E0F0;
                    end else if (is_e0) begin
                        state_d = GOT_E0;
                    end else if (is_err) begin
                        state_d = IDLE;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (is_f0 || is_e0) begin
                        state_d = GOT_E0F0;
                    end else if (is_err) begin
                        state_d = IDLE;
                    end else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        if (byte_valid || (state_q == IDLE) || timeout_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [8:0]            mem_q [FIFO_DEPTH];   // {code, break}
`ifdef PS2_EXTENDED_EN
    logic                  ext_mem_q [FIFO_DEPTH];
`endif
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q;
    logic                  full, pop, push, drop;
    logic [FIFO_DEPTH-1:0] we;

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = ev_valid && ev_ready;
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    assign push = emit && (!full || pop);
    assign drop = emit && full && !pop;

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
        assign we[gi] = push && (wr_ptr_q == AW'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (we[i]) begin
                mem_q[i] <= {byte_in, emit_brk};
`ifdef PS2_EXTENDED_EN
                ext_mem_q[i] <= emit_ext;
`endif
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Storage is not reset; outputs are forced to zero while empty.
    assign ev_valid   = (count_q != '0);
    assign fifo_count = count_q;
    assign ovf        = ovf_q;
    assign ev_code    = ev_valid ? mem_q[rd_ptr_q][8:1] : 8'h00;
    assign ev_break   = ev_valid && mem_q[rd_ptr_q][0];
`ifdef PS2_EXTENDED_EN
    assign ev_ext     = ev_valid && ext_mem_q[rd_ptr_q];
`else
    assign ev_ext     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
`ifdef PS2_EXTENDED_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       ovf;
    logic [$clog2(DEPTH):0] fifo_count;

    int errors = 0;
    int checks = 0;

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_break   (ev_break),
        .ev_ext     (ev_ext),
        .ovf        (ovf),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } ev_t;

    ev_t m_q[$];
    bit  m_brk, m_ext, m_ovf;
    int  m_gap;

    task automatic model_step(input bit r, input bit v, input logic [7:0] b, input bit rdy);
        bit   pop;
        bit   em;
        ev_t  e;
        if (r) begin
            m_q.delete();
            m_brk = 0; m_ext = 0; m_ovf = 0; m_gap = 0;
            return;
        end
        pop = (m_q.size() != 0) && rdy;
        em  = 0;
        e   = '{code: b, brk: 1'b0, ext: 1'b0};
        if (v) begin
            m_gap = 0;
            if (b == 8'hE0) begin
                if (EXT) begin
                    if (!m_ext) m_brk = 0;   // fresh extended sequence
                    m_ext = 1;
                end
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b == 8'h00 || b == 8'hFF) begin
                m_brk = 0; m_ext = 0;
            end else begin
                em = 1;
                e.brk = m_brk; e.ext = m_ext;
                m_brk = 0; m_ext = 0;
            end
        end else if (m_brk || m_ext) begin
            m_gap++;
            if (m_gap >= TMO) begin
                m_brk = 0; m_ext = 0; m_gap = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (em) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else m_ovf = 1;
        end
    endtask

    task automatic model_check();
        bit ok;
        int exp_cnt;
        exp_cnt = m_q.size();
        ok = (ev_valid == (exp_cnt != 0)) && (int'(fifo_count) == exp_cnt) && (ovf == m_ovf);
        if (exp_cnt != 0)
            ok = ok && (ev_code == m_q[0].code) && (ev_break == m_q[0].brk) && (ev_ext == m_q[0].ext);
        checks++;
        if (!ok) begin
            errors++;
            if (exp_cnt != 0)
                $display("FAIL model t=%0t: got valid=%0b cnt=%0d ovf=%0b head=%02h/%0b/%0b, expected valid=1 cnt=%0d ovf=%0b head=%02h/%0b/%0b",
                         $time, ev_valid, fifo_count, ovf, ev_code, ev_break, ev_ext,
                         exp_cnt, m_ovf, m_q[0].code, m_q[0].brk, m_q[0].ext);
            else
                $display("FAIL model t=%0t: got valid=%0b cnt=%0d ovf=%0b, expected valid=0 cnt=0 ovf=%0b",
                         $time, ev_valid, fifo_count, ovf, m_ovf);
        end
    endtask

    // One clock: drive, let the edge happen, step model, sample 1 ns later.
    task automatic cycle(input bit r, input bit v, input logic [7:0] b, input bit rdy);
        rst = r; byte_valid = v; byte_in = b; ev_ready = rdy;
        @(posedge clk);
        model_step(r, v, b, rdy);
        #1;
        model_check();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int head();
        return {22'd0, ev_code, ev_break, ev_ext};
    endfunction

    function automatic int mk(input logic [7:0] c, input bit b, input bit x);
        return {22'd0, c, b, x};
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        bit         v;
        logic [7:0] b;
        bit         rdy;
        bit         e_valid;
        logic [7:0] e_code;
        bit         e_brk;
        bit         e_ext;
        int         e_cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b0, EXT,  1};
        tbl[7]  = '{1'b1, 8'hE0, 1'b0, 1'b1, 8'h75, 1'b0, EXT,  1};
        tbl[8]  = '{1'b1, 8'hF0, 1'b0, 1'b1, 8'h75, 1'b0, EXT,  1};
        tbl[9]  = '{1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b0, EXT,  2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h75, 1'b1, EXT,  1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};

        // Reset state
        cycle(1, 0, 8'h00, 0);
        cycle(1, 1, 8'h2A, 1);
        chk("reset_valid", int'(ev_valid), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_head", head(), 0);

        // Basic make/break and extended keys, one check set per row
        for (int i = 0; i < 14; i++) begin
            cycle(0, tbl[i].v, tbl[i].b, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), int'(ev_valid), int'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_count", i), int'(fifo_count), tbl[i].e_cnt);
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d_head", i), head(), mk(tbl[i].e_code, tbl[i].e_brk, tbl[i].e_ext));
        end

        // Overflow: six makes into a depth-4 FIFO with no consumer
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 8'h15 + 8'(i), 0);
        chk("ovf_count", int'(fifo_count), DEPTH);
        chk("ovf_flag", int'(ovf), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_pop%0d", i), int'(ev_code), 'h15 + i);
            cycle(0, 0, 8'h00, 1);
        end
        chk("ovf_empty", int'(ev_valid), 0);
        chk("ovf_sticky", int'(ovf), 1);

        // Full FIFO with simultaneous push and pop
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'h15 + 8'(i), 0);
        chk("full_count", int'(fifo_count), DEPTH);
        cycle(0, 1, 8'h29, 1);
        chk("pp_count", int'(fifo_count), DEPTH);
        chk("pp_ovf", int'(ovf), 0);
        begin
            logic [7:0] exp_codes [4];
            exp_codes[0] = 8'h16; exp_codes[1] = 8'h17;
            exp_codes[2] = 8'h18; exp_codes[3] = 8'h29;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("pp_pop%0d", i), int'(ev_code), int'(exp_codes[i]));
                cycle(0, 0, 8'h00, 1);
            end
        end
        chk("pp_empty", int'(ev_valid), 0);

        // Timeout: a stale F0 must not turn the next make into a break
        cycle(1, 0, 8'h00, 0);
        cycle(0, 1, 8'hF0, 0);
        repeat (TMO) cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h1C, 0);
        chk("tmo_count", int'(fifo_count), 1);
        chk("tmo_head", head(), mk(8'h1C, 1'b0, 1'b0));

        // One cycle short of the timeout the prefix still applies
        cycle(1, 0, 8'h00, 0);
        cycle(0, 1, 8'hF0, 0);
        repeat (TMO - 1) cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h1C, 0);
        chk("tmo_edge_head", head(), mk(8'h1C, 1'b1, 1'b0));

        // Reset discards a pending prefix
        cycle(1, 0, 8'h00, 0);
        cycle(0, 1, 8'hE0, 0);
        cycle(1, 0, 8'h00, 0);
        cycle(0, 1, 8'h6B, 0);
        chk("rst_prefix_count", int'(fifo_count), 1);
        chk("rst_prefix_head", head(), mk(8'h6B, 1'b0, 1'b0));

        // Randomized traffic against the model
        cycle(1, 0, 8'h00, 0);
        begin
            int rdy_pct;
            rdy_pct = 50;
            for (int n = 0; n < 4000; n++) begin
                int         sel;
                logic [7:0] b;
                bit         v;
                bit         rdy;
                if (n % 250 == 0) rdy_pct = $urandom_range(0, 100);
                if ($urandom_range(0, 99) == 0) begin
                    repeat ($urandom_range(TMO - 2, TMO + 3))
                        cycle(0, 0, 8'h00, ($urandom_range(0, 99) < rdy_pct));
                end
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1:    b = 8'hE0;
                    2, 3:    b = 8'hF0;
                    4:       b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                    default: b = 8'($urandom);
                endcase
                v   = ($urandom_range(0, 2) != 0);
                rdy = ($urandom_range(0, 99) < rdy_pct);
                cycle(($urandom_range(0, 499) == 0), v, b, rdy);
            end
        end

        byte_valid = 1'b0;
        ev_ready   = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
